// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter family: FSM encodings and default widths.
package mem_pkg;
  localparam int MEM_BITS_DEF   = 5;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ISSUE = 4'd1,
    WAIT  = 4'd2,
    RESP  = 4'd3
  } mem_state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: one-hot or zero, the requester not granted last wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end
endmodule

// File: rtl/mem_arbiter.sv
// Serialises two requesters onto one memory port: latch, issue a one-cycle strobe,
// wait for mem_ready, then return a one-cycle ack to the granted requester.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MEMORY_BITS = MEM_BITS_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_0,
  input  logic                   we_0,
  input  logic [MEMORY_BITS-1:0] addr_0,
  input  logic [DATA_WIDTH-1:0]  wdata_0,
  output logic                   ack_0,
  output logic [DATA_WIDTH-1:0]  rdata_0,
  input  logic                   req_1,
  input  logic                   we_1,
  input  logic [MEMORY_BITS-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0]  wdata_1,
  output logic                   ack_1,
  output logic [DATA_WIDTH-1:0]  rdata_1,
  output logic [MEMORY_BITS-1:0] fulladdress,
  output logic                   read_signal,
  output logic                   write_signal,
  output logic [DATA_WIDTH-1:0]  out_write,
  input  logic [DATA_WIDTH-1:0]  out_read,
  input  logic                   mem_ready,
  output logic [3:0]             state
);
  mem_state_e             state_q, state_d;
  logic [1:0]             req_vec, grant;
  logic                   gnt_q;
  logic                   we_q;
  logic [MEMORY_BITS-1:0] addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q, rdata0_q, rdata1_q;
  logic                   latch_en, rd_done;

  assign req_vec = {req_1, req_0};

  // gnt_q doubles as the last-grant memory for round-robin
  rr_arb2 u_arb (
    .req   (req_vec),
    .last  (gnt_q),
    .grant (grant)
  );

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          latch_en = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (mem_ready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_done = (state_q == WAIT) && mem_ready && !we_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        gnt_q   <= grant[1];
        we_q    <= grant[1] ? we_1    : we_0;
        addr_q  <= grant[1] ? addr_1  : addr_0;
        wdata_q <= grant[1] ? wdata_1 : wdata_0;
      end
      if (rd_done) begin
        if (gnt_q) rdata1_q <= out_read;
        else       rdata0_q <= out_read;
      end
    end
  end

  assign state        = state_q;
  assign fulladdress  = addr_q;
  assign out_write    = wdata_q;
  assign read_signal  = (state_q == ISSUE) && !we_q;
  assign write_signal = (state_q == ISSUE) && we_q;
  assign ack_0        = (state_q == RESP) && !gnt_q;
  assign ack_1        = (state_q == RESP) && gnt_q;
  assign rdata_0      = rdata0_q;
  assign rdata_1      = rdata1_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL take parameter MEMORY_BITS, default 5, giving the word-address width of the shared memory.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 32, giving the data word width.
REQ-003 The block SHALL have a single clock port clk, input, 1 bit, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-005 The block SHALL provide, for requester n in {0,1}: req_n input 1 (request pending), we_n input 1 (1 = write, 0 = read), addr_n input MEMORY_BITS (word address), wdata_n input DATA_WIDTH (write data).
REQ-006 The block SHALL provide, for requester n in {0,1}: ack_n output 1 (one-cycle completion pulse) and rdata_n output DATA_WIDTH (read data, valid while ack_n is high).
REQ-007 The block SHALL drive the memory port outputs fulladdress (MEMORY_BITS), read_signal (1), write_signal (1) and out_write (DATA_WIDTH).
REQ-008 The block SHALL accept memory port inputs out_read (DATA_WIDTH, read data) and mem_ready (1, one-cycle completion pulse from memory).
REQ-009 The block SHALL output state, 4 bits, carrying the current FSM encoding for debug.

Function
REQ-010 The FSM SHALL use states IDLE=0, ISSUE=1, WAIT=2 and RESP=3; encodings 4 to 15 are unused and SHALL return to IDLE.
REQ-011 In IDLE with any req_n high, the block SHALL grant one requester, latch its we, addr and wdata into internal registers, and move to ISSUE on the next edge.
REQ-012 Arbitration SHALL be round-robin: when both requests are high, the requester not granted last wins; after reset, requester 0 has priority.
REQ-013 In ISSUE, the block SHALL hold read_signal or write_signal high for exactly one cycle according to the latched we, with fulladdress and out_write driven from the latched values, then move to WAIT.
REQ-014 In WAIT, fulladdress and out_write SHALL remain stable, read_signal and write_signal SHALL be low, and the FSM SHALL stay in WAIT until mem_ready is high.
REQ-015 On mem_ready in WAIT, the block SHALL capture out_read into the granted requester's rdata register when the access is a read, and move to RESP.
REQ-016 In RESP, the block SHALL pulse ack of the granted requester only, for exactly one cycle, then return to IDLE.
REQ-017 Minimum latency SHALL be 4 cycles from req sampled in IDLE to ack, given mem_ready in the first WAIT cycle.
REQ-018 A requester SHALL hold req, we, addr and wdata until its ack; the block ignores changes after the latch cycle.
REQ-019 A requester that keeps req high in the cycle after ack SHALL be treated as a new request; round-robin still applies.
REQ-020 A mem_ready pulse outside WAIT SHALL be ignored.
REQ-021 rdata_n SHALL hold its value until the next read completes for that requester; a write SHALL NOT alter rdata_n.
REQ-022 A read and a write SHALL never be asserted in the same cycle.

Reset
REQ-023 Asserting reset SHALL immediately force state=IDLE, read_signal=0, write_signal=0, ack_0=ack_1=0, fulladdress=0, out_write=0, rdata_0=rdata_1=0, and set last-grant so that requester 0 has priority.
REQ-024 Asserting reset during ISSUE, WAIT or RESP SHALL abort the transaction without an ack; after reset is released, the requester re-arbitrates from IDLE.

Structure
REQ-025 The state encodings and default widths SHALL live in a shared package mem_pkg, reused by the memory and combined modules.
REQ-026 Grant selection SHALL be a sub-module rr_arb2, with inputs req[1:0] and last and output grant[1:0], combinational and one-hot or zero.

Verification
REQ-027 Single read: reset, then req_0=1, we_0=0, addr_0=12, with memory returning 0xDEADBEEF on mem_ready in the first WAIT cycle. Required: read_signal pulses once with fulladdress=12, ack_0 arrives 4 cycles after the request, and rdata_0=0xDEADBEEF.
REQ-028 Single write: req_1=1, we_1=1, addr_1=20, wdata_1=6. Required: write_signal pulses once with fulladdress=20 and out_write=6, ack_1 fires, and rdata_1 is unchanged.
REQ-029 Contention: req_0 and req_1 held high continuously for 4 transactions. Required: grant order 0,1,0,1 and no cycle with both acks high.
REQ-030 Slow memory: mem_ready delayed 7 cycles. Required: the FSM stays in WAIT (state=2) for 7 cycles, fulladdress is stable throughout, and ack follows 1 cycle after mem_ready.
REQ-031 Reset mid-operation: assert reset while state=2. Required: all outputs are 0 and state=0 in the same cycle, no ack is issued, and a held req is re-served after release.
REQ-032 Spurious mem_ready in IDLE: pulse mem_ready with no request pending. Required: state stays 0, no ack is issued, and rdata is unchanged.
